// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
// Parallel-in / serial-out transmitter. A WIDTH-bit word is taken over a
// valid/ready handshake and sent LSB-first, one bit per clock, on sout.
// An even-parity bit may be appended to each frame.
//
// Compile-time option:
//   SERIAL_TX_PARITY_EN  when defined, each frame carries WIDTH data bits
//                        followed by one even-parity bit (WIDTH+1 cycles).
//
// Parameters:
//   WIDTH       data bits per frame (2..32)
//
// Ports:
//   clk         rising-edge clock
//   rst_AL      asynchronous active-low reset
//   load_valid  load_data is valid this cycle
//   load_data   word to transmit, bit 0 sent first
//   load_ready  a word will be accepted at the next rising edge
//   sout        serial data bit (registered)
//   sout_valid  sout carries a frame bit this cycle (registered)
//   last        sout is the final bit of the frame (registered)
// -----------------------------------------------------------------------------
module serial_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_AL,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
`ifndef SERIAL_TX_PARITY_EN
  localparam logic [CW-1:0] PRE_LAST_IDX = CW'(WIDTH - 2);
`endif

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;
`endif

  // r_shift holds the bits not yet on sout; the current bit lives in r_sout.
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-2:0] w_shift_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_sout;
  logic             w_sout_nxt;
  logic             r_sout_valid;
  logic             w_sout_valid_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             w_load_ready;
  logic             w_accept;
`ifdef SERIAL_TX_PARITY_EN
  logic             r_par;
  logic             w_par_nxt;
`endif

  // Ready in IDLE and on the final bit of a frame, enabling gapless frames.
  always_comb begin
    w_load_ready = 1'b0;
    if (r_state == ST_IDLE) begin
      w_load_ready = 1'b1;
    end else begin
      w_load_ready = r_last;
    end
  end

  assign w_accept   = load_valid & w_load_ready;
  assign load_ready = w_load_ready;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign last       = r_last;

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_cnt_nxt        = r_cnt;
    w_sout_nxt       = 1'b0;
    w_sout_valid_nxt = 1'b0;
    w_last_nxt       = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    w_par_nxt        = r_par;
`endif
    if (w_accept) begin
      // New word: bit 0 goes straight onto sout, the rest wait in r_shift.
      w_state_nxt      = ST_SHIFT;
      w_shift_nxt      = load_data[WIDTH-1:1];
      w_cnt_nxt        = {CW{1'b0}};
      w_sout_nxt       = load_data[0];
      w_sout_valid_nxt = 1'b1;
      w_last_nxt       = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      w_par_nxt        = load_data[0];
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_SHIFT: begin
          if (r_cnt == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
            // Accumulator already covers all WIDTH data bits.
            w_state_nxt      = ST_PARITY;
            w_sout_nxt       = r_par;
            w_sout_valid_nxt = 1'b1;
            w_last_nxt       = 1'b1;
`else
            w_state_nxt = ST_IDLE;
            w_shift_nxt = {(WIDTH-1){1'b0}};
            w_cnt_nxt   = {CW{1'b0}};
`endif
          end else begin
            w_state_nxt      = ST_SHIFT;
            w_shift_nxt      = r_shift >> 1;
            w_cnt_nxt        = r_cnt + CW'(1);
            w_sout_nxt       = r_shift[0];
            w_sout_valid_nxt = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            w_last_nxt       = 1'b0;
            w_par_nxt        = r_par ^ r_shift[0];
`else
            w_last_nxt       = (r_cnt == PRE_LAST_IDX);
`endif
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          w_state_nxt = ST_IDLE;
          w_shift_nxt = {(WIDTH-1){1'b0}};
          w_cnt_nxt   = {CW{1'b0}};
          w_par_nxt   = 1'b0;
        end
`endif
        default: begin
          // Illegal encoding: fall back to a clean idle.
          w_state_nxt = ST_IDLE;
          w_shift_nxt = {(WIDTH-1){1'b0}};
          w_cnt_nxt   = {CW{1'b0}};
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_AL) begin
    if (!rst_AL) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_AL) begin
    if (!rst_AL) begin
      r_shift      <= {(WIDTH-1){1'b0}};
      r_cnt        <= {CW{1'b0}};
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_last       <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sout       <= w_sout_nxt;
      r_sout_valid <= w_sout_valid_nxt;
      r_last       <= w_last_nxt;
`ifdef SERIAL_TX_PARITY_EN
      r_par        <= w_par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx
// Self-checking bench for serial_tx. A reference model tracks the frame in
// flight; every accepted word pushes its expected {bit, last} sequence onto a
// scoreboard queue that is popped and compared one entry per clock. Each test
// task also makes its own scenario-specific comparisons.
// -----------------------------------------------------------------------------
module tb_serial_tx;

  localparam int WIDTH = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic             clk        = 1'b0;
  logic             rst_AL     = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data  = '0;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             last;

  int         errors    = 0;
  int         checks    = 0;
  logic [1:0] sb_q[$];
  logic [1:0] exp_e;
  int         m_rem     = 0;  // frame bits still to appear, including the current one
  int         m_acc_cnt = 0;  // words the model has accepted

  serial_tx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_AL     (rst_AL),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .last       (last)
  );

  always #5 clk = ~clk;

  // Asynchronous reset discards whatever frame the model had in flight.
  always @(negedge rst_AL) begin
    sb_q.delete();
    m_rem = 0;
  end

  // Reference model and scoreboard: check ready, accept, then check outputs.
  always @(posedge clk) begin
    if (!rst_AL) begin
      sb_q.delete();
      m_rem = 0;
    end else begin
      checks++;
      if (load_ready !== (m_rem <= 1)) begin
        errors++;
        $display("FAIL ready @%0t: got %b want %b", $time, load_ready, (m_rem <= 1));
      end
      if (load_valid && (m_rem <= 1)) begin
        for (int i = 0; i < WIDTH; i++) sb_q.push_back({load_data[i], (i == FL - 1)});
`ifdef SERIAL_TX_PARITY_EN
        sb_q.push_back({^load_data, 1'b1});
`endif
        m_rem = FL;
        m_acc_cnt++;
      end else if (m_rem > 0) begin
        m_rem--;
      end
    end
    #1;
    if (m_rem > 0) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty @%0t", $time);
      end else begin
        exp_e = sb_q.pop_front();
        checks++;
        if (sout_valid !== 1'b1 || sout !== exp_e[1] || last !== exp_e[0]) begin
          errors++;
          $display("FAIL frame_bit @%0t: got valid=%b sout=%b last=%b want valid=1 sout=%b last=%b",
                   $time, sout_valid, sout, last, exp_e[1], exp_e[0]);
        end
      end
    end else begin
      checks++;
      if (sout_valid !== 1'b0 || sout !== 1'b0 || last !== 1'b0) begin
        errors++;
        $display("FAIL idle_out @%0t: got valid=%b sout=%b last=%b want 0 0 0",
                 $time, sout_valid, sout, last);
      end
    end
  end

  task automatic test_reset();
    load_valid = 1'b1;
    load_data  = 8'hA5;
    repeat (2) @(negedge clk);
    checks++;
    if ({sout, sout_valid, last, load_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_hold: got sout/valid/last/ready=%b want 0001",
               {sout, sout_valid, last, load_ready});
    end
    load_valid = 1'b0;
    rst_AL     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({sout, sout_valid, last, load_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL reset_idle%0d: got %b want 0001", c, {sout, sout_valid, last, load_ready});
      end
    end
  endtask

  task automatic test_single_frame();
    logic [WIDTH-1:0] word;
    int lastcnt;
    int lastpos;
    word = '0; lastcnt = 0; lastpos = -1;
    load_valid = 1'b1;
    load_data  = 8'hA5;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i < WIDTH) word[i] = sout;
      if (last) begin lastcnt++; lastpos = i; end
      @(negedge clk);
    end
    checks++;
    if (word !== 8'hA5) begin
      errors++;
      $display("FAIL single_word: got %h want a5", word);
    end
    checks++;
    if (lastcnt != 1 || lastpos != FL - 1) begin
      errors++;
      $display("FAIL single_last: got count=%0d pos=%0d want 1 at %0d", lastcnt, lastpos, FL - 1);
    end
    checks++;
    if (sout_valid !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: got valid=%b ready=%b want 0 1", sout_valid, load_ready);
    end
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity(input logic [WIDTH-1:0] d, input logic exp_par);
    logic pbit;
    logic plast;
    pbit = 1'bx; plast = 1'b0;
    load_valid = 1'b1;
    load_data  = d;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i == FL - 1) begin pbit = sout; plast = last; end
      @(negedge clk);
    end
    checks++;
    if (pbit !== exp_par || plast !== 1'b1) begin
      errors++;
      $display("FAIL parity_%h: got bit=%b last=%b want bit=%b last=1", d, pbit, plast, exp_par);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int start;
    int ready_hi;
    int run;
    int ones;
    bit seen;
    bit done;
    start = m_acc_cnt; ready_hi = 0; run = 0; ones = 0; seen = 1'b0; done = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    for (int c = 0; c < 40 && !done; c++) begin
      if (load_ready) ready_hi++;
      @(negedge clk);
      if (m_acc_cnt == start + 1) load_data = 8'h00;
      else if (m_acc_cnt >= start + 2) load_valid = 1'b0;
      if (sout_valid) begin
        run++;
        ones += int'(sout);
        seen = 1'b1;
      end else if (seen) begin
        done = 1'b1;
      end
    end
    load_valid = 1'b0;
    checks++;
    if (run != 2 * FL || !done) begin
      errors++;
      $display("FAIL b2b_run: got %0d contiguous valid bits (ended=%0d) want %0d", run, done, 2 * FL);
    end
    checks++;
    if (ones != WIDTH) begin
      errors++;
      $display("FAIL b2b_ones: got %0d want %0d", ones, WIDTH);
    end
    checks++;
    if (ready_hi != 3) begin
      errors++;
      $display("FAIL b2b_ready: got %0d ready cycles want 3", ready_hi);
    end
  endtask

  task automatic test_backpressure();
    load_valid = 1'b1;
    load_data  = 8'hA5;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    // Bit 2 is on sout; request a new word mid-frame.
    load_valid = 1'b1;
    load_data  = 8'h3C;
    for (int b = 2; b < FL; b++) begin
      checks++;
      if (load_ready !== (b == FL - 1)) begin
        errors++;
        $display("FAIL bp_ready_bit%0d: got %b want %b", b, load_ready, (b == FL - 1));
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    repeat (FL + 2) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [WIDTH-1:0] word;
    word = '0;
    load_valid = 1'b1;
    load_data  = 8'hA5;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_AL = 1'b0;
    #1;
    checks++;
    if ({sout, sout_valid, last, load_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_async: got sout/valid/last/ready=%b want 0001",
               {sout, sout_valid, last, load_ready});
    end
    @(negedge clk);
    rst_AL = 1'b1;
    repeat (2) @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'h81;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      word[i] = sout;
      @(negedge clk);
    end
    checks++;
    if (word !== 8'h81) begin
      errors++;
      $display("FAIL midreset_reload: got %h want 81", word);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_frame();
`ifdef SERIAL_TX_PARITY_EN
    test_parity(8'hA5, 1'b0);
    test_parity(8'h07, 1'b1);
`endif
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_backpressure();
    test_reset_midframe();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
